forest_vote_scheduler: RTL

- Sequences a sample through NUM_TREES parallel decision-tree classifier instances and forms the forest result by majority vote.
- Accepts one fixed-point feature vector per valid/ready handshake and broadcasts it to all trees.
- Clears the trees, runs the traversal, collects each tree's done/label, and presents a voted label on a valid/ready output.
- Sits between the sample source (UART/feature buffer) and the result sink.

---
 rtl/forest_vote_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/forest_vote_scheduler.sv
// Drives NUM_TREES decision-tree instances with one broadcast sample, collects
// their done/label results and presents the majority vote on a valid/ready output.
module forest_vote_scheduler #(
   parameter int NUM_TREES  = 3,
   parameter int NUM_FEAT   = 11,
   parameter int FEAT_W     = 16,
   parameter int TREE_DEPTH = 3,
   parameter int TIMEOUT    = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [NUM_FEAT*FEAT_W-1:0]   s_features,
   output logic [NUM_FEAT*FEAT_W-1:0]   tree_features,
   output logic                         tree_reset_n,
   output logic                         tree_start,
   output logic [3:0]                   tree_depth,
   input  logic [NUM_TREES-1:0]         tree_done,
   input  logic [NUM_TREES-1:0]         tree_label,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_label,
   output logic [2:0]                   m_votes,
   output logic                         m_timeout,
   output logic                         busy,
   output logic [15:0]                  sample_count
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_VOTE,
      S_OUT
   } state_t;

   state_t                 state, state_nxt;
   logic [NUM_TREES-1:0]   done_mask, vote_reg;
   logic [NUM_TREES-1:0]   mask_upd, vote_upd;
   logic [CNT_W-1:0]       run_cnt;
   logic [2:0]             pop;
   logic                   all_done, run_expired;

   // Handshakes: a transfer occurs on a clk edge where valid && ready are both
   // high; the source holds data stable while valid is high and ready is low.
   assign s_ready      = (state == S_IDLE);
   assign m_valid      = (state == S_OUT);
   assign busy         = (state != S_IDLE);
   assign tree_start   = (state == S_RUN);
   assign tree_reset_n = reset && (state != S_CLEAR);
   assign tree_depth   = 4'(TREE_DEPTH);

   always_comb begin
      mask_upd    = done_mask | tree_done;
      vote_upd    = vote_reg | (tree_done & ~done_mask & tree_label);
      all_done    = &mask_upd;
      run_expired = (run_cnt == CNT_W'(TIMEOUT - 1));
      pop         = '0;
      for (int i = 0; i < NUM_TREES; i++) begin
         pop = pop + 3'(vote_reg[i] & done_mask[i]);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (s_valid) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_RUN;
         S_RUN:   if (all_done || run_expired) state_nxt = S_VOTE;
         S_VOTE:  state_nxt = S_OUT;
         S_OUT:   if (m_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         tree_features <= '0;
         done_mask     <= '0;
         vote_reg      <= '0;
         run_cnt       <= '0;
         m_label       <= 1'b0;
         m_votes       <= '0;
         m_timeout     <= 1'b0;
         sample_count  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (s_valid) tree_features <= s_features;
            end
            S_CLEAR: begin
               done_mask <= '0;
               vote_reg  <= '0;
               run_cnt   <= '0;
            end
            S_RUN: begin
               done_mask <= mask_upd;
               vote_reg  <= vote_upd;
               run_cnt   <= run_cnt + CNT_W'(1);
               // A full mask on the timeout edge still counts as a clean finish.
               if (all_done)         m_timeout <= 1'b0;
               else if (run_expired) m_timeout <= 1'b1;
            end
            S_VOTE: begin
               m_votes <= pop;
               m_label <= (2 * int'(pop)) > NUM_TREES;
            end
            S_OUT: begin
               if (m_ready) sample_count <= sample_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
